// File: rtl/platform_pkg.sv
// Shared types and constants for the platform table: geometry, entry layout
// and the power-on arrangement of platforms.
package platform_pkg;

  localparam int NUM_PLAT = 16;
  localparam int IDX_W    = $clog2(NUM_PLAT);
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } plat_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } sched_state_t;

  function automatic coord_t init_x(input int i);
    return coord_t'(40 * i + 20);
  endfunction

  function automatic coord_t init_y(input int i);
    return coord_t'(30 * i + 15);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] state
);

  // Right-shifting Galois form: feedback taps folded into mask 16'hB400.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/platform_scheduler.sv
// Per-frame platform scroller: scans the working table one entry per clock,
// respawns fallen platforms at the top and publishes the result atomically.
module platform_scheduler
  import platform_pkg::*;
#(
  parameter int          SCROLL_LINE = 200,
  parameter int          MAX_SCROLL  = 16,
  parameter int          X_MARGIN    = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic                      run,
  input  logic [9:0]                BallY,
  output logic [NUM_PLAT*10-1:0]    PlatX,
  output logic [NUM_PLAT*10-1:0]    PlatY,
  output logic [9:0]                Scroll,
  output logic                      update_done,
  output logic                      busy,
  output logic [15:0]               Score,
  output logic                      overrun
);

  localparam coord_t             SCROLL_LINE_C = coord_t'(SCROLL_LINE);
  localparam coord_t             MAX_SCROLL_C  = coord_t'(MAX_SCROLL);
  localparam coord_t             X_MARGIN_C    = coord_t'(X_MARGIN);
  localparam logic [10:0]        SCREEN_H_C    = 11'(SCREEN_H);
  localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NUM_PLAT - 1);

  sched_state_t      state_r;
  logic [2:0]        sync_r;
  logic              tick_s;
  logic [IDX_W-1:0]  idx_r;
  coord_t            dy_r;
  coord_t            diff_s;
  coord_t            dy_s;
  logic [10:0]       sum_s;
  coord_t            new_x_s;
  coord_t            new_y_s;
  logic [16:0]       score_sum_s;
  logic [15:0]       lfsr_s;
  logic              unused_lfsr_s;
  plat_t             work_r [NUM_PLAT];
  plat_t             pub_r  [NUM_PLAT];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .state   (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:9];
  assign tick_s        = sync_r[1] & ~sync_r[2];

  // Scroll amount, per-entry shift/respawn and saturating score arithmetic.
  always_comb begin
    diff_s      = SCROLL_LINE_C - BallY;
    dy_s        = 10'd0;
    if (BallY < SCROLL_LINE_C) begin
      dy_s = (diff_s > MAX_SCROLL_C) ? MAX_SCROLL_C : diff_s;
    end else begin
      dy_s = 10'd0;
    end
    sum_s       = {1'b0, work_r[idx_r].y} + {1'b0, dy_r};
    new_x_s     = work_r[idx_r].x;
    new_y_s     = sum_s[9:0];
    if (sum_s >= SCREEN_H_C) begin
      new_y_s = coord_t'(sum_s - SCREEN_H_C);
      new_x_s = X_MARGIN_C + {1'b0, lfsr_s[8:0]};
    end else begin
      new_y_s = sum_s[9:0];
      new_x_s = work_r[idx_r].x;
    end
    score_sum_s = {1'b0, Score} + {7'b0000000, dy_r};
  end

  // Flatten the published table onto the packed output buses.
  always_comb begin
    PlatX = '0;
    PlatY = '0;
    for (int i = 0; i < NUM_PLAT; i++) begin
      PlatX[10*i +: 10] = pub_r[i].x;
      PlatY[10*i +: 10] = pub_r[i].y;
    end
  end

  // Frame-tick synchronizer plus the IDLE/SCAN/PUBLISH sequencer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        work_r[i] <= '{x: init_x(i), y: init_y(i)};
        pub_r[i]  <= '{x: init_x(i), y: init_y(i)};
      end
      state_r     <= ST_IDLE;
      sync_r      <= 3'b000;
      idx_r       <= '0;
      dy_r        <= 10'd0;
      Scroll      <= 10'd0;
      Score       <= 16'd0;
      update_done <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync_r      <= {sync_r[1:0], frame_clk};
      update_done <= 1'b0;
      if (tick_s && (state_r != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (tick_s && run && (dy_s != 10'd0)) begin
            dy_r    <= dy_s;
            idx_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          work_r[idx_r] <= '{x: new_x_s, y: new_y_s};
          idx_r         <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          if (idx_r == LAST_IDX) begin
            state_r <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          for (int i = 0; i < NUM_PLAT; i++) begin
            pub_r[i] <= work_r[i];
          end
          Scroll      <= dy_r;
          Score       <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
          update_done <= 1'b1;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed plus randomized frames checked against a table-level model of the
// scroll/respawn rules.
module tb_platform_scheduler;

  logic         Clk       = 1'b0;
  logic         Reset_n   = 1'b0;
  logic         frame_clk = 1'b0;
  logic         run       = 1'b0;
  logic [9:0]   BallY     = 10'd0;
  logic [159:0] PlatX;
  logic [159:0] PlatY;
  logic [9:0]   Scroll;
  logic         update_done;
  logic         busy;
  logic [15:0]  Score;
  logic         overrun;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;

  int   mx [16];
  int   my [16];
  int   m_score;
  int   m_scroll;
  logic m_over;
  logic [15:0] m_lfsr;

  platform_scheduler dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .run         (run),
    .BallY       (BallY),
    .PlatX       (PlatX),
    .PlatY       (PlatY),
    .Scroll      (Scroll),
    .update_done (update_done),
    .busy        (busy),
    .Score       (Score),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Reset_n && update_done) pulses++;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = lfsr_next(r);
    return r;
  endfunction

  // Free-running reference copy of the random source.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 16; i++) begin
      mx[i] = 40 * i + 20;
      my[i] = 30 * i + 15;
    end
    m_score  = 0;
    m_scroll = 0;
    m_over   = 1'b0;
  endtask

  task automatic check_table(input string tag);
    logic [159:0] ex;
    logic [159:0] ey;
    for (int i = 0; i < 16; i++) begin
      ex[10*i +: 10] = 10'(mx[i]);
      ey[10*i +: 10] = 10'(my[i]);
    end
    check({tag, "_x"}, PlatX, ex);
    check({tag, "_y"}, PlatY, ey);
  endtask

  // One raw frame_clk rise; inject re-raises it while the scan is running.
  task automatic frame(input logic [9:0] ball, input logic run_v, input bit inject, input bit wobble_run);
    int          dy;
    int          s;
    int          p0;
    bit          exp;
    logic [15:0] l;
    logic [15:0] r;
    dy  = 0;
    if (run_v && ball < 10'd200) dy = (200 - int'(ball) > 16) ? 16 : 200 - int'(ball);
    exp = (dy > 0);
    BallY = ball;
    run   = run_v;
    @(posedge Clk);
    #1;
    frame_clk = 1'b1;
    l  = m_lfsr;
    p0 = pulses;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk);
      #1;
      if (inject && c == 4) frame_clk = 1'b0;
      if (inject && c == 6) frame_clk = 1'b1;
      if (wobble_run && c == 8) run = 1'($urandom_range(1, 0));
      if (c == 10) check("busy_mid", 160'(busy), 160'(exp));
      if (c == 19) check("done_early", 160'(update_done), 160'd0);
      if (c == 20) check("done_at_20", 160'(update_done), 160'(exp));
    end
    if (exp) begin
      for (int k = 0; k < 16; k++) begin
        s = my[k] + dy;
        if (s >= 480) begin
          my[k] = s - 480;
          r     = lfsr_adv(l, 3 + k);
          mx[k] = 64 + int'(r[8:0]);
        end else begin
          my[k] = s;
        end
      end
      m_scroll = dy;
      m_score  = (m_score + dy > 65535) ? 65535 : m_score + dy;
      if (inject) m_over = 1'b1;
    end
    check("busy_end", 160'(busy), 160'd0);
    check("scroll", 160'(Scroll), 160'(m_scroll));
    check("score", 160'(Score), 160'(m_score));
    check_table("table");
    frame_clk = 1'b0;
    run = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("pulse_count", 160'(pulses - p0), 160'(exp));
    check("overrun", 160'(overrun), 160'(m_over));
  endtask

  initial begin
    init_model();
    #12;
    check("rst_busy", 160'(busy), 160'd0);
    check("rst_score", 160'(Score), 160'd0);
    check_table("rst_table");
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (30) @(posedge Clk);
    #1;
    check("idle_e3x", 160'(PlatX[39:30]), 160'd140);
    check("idle_e3y", 160'(PlatY[39:30]), 160'd105);
    check("idle_e15x", 160'(PlatX[159:150]), 160'd620);
    check("idle_e15y", 160'(PlatY[159:150]), 160'd465);
    check("idle_pulses", 160'(pulses), 160'd0);

    frame(10'd190, 1'b1, 1'b0, 1'b0);
    check("e0y_25", 160'(PlatY[9:0]), 160'd25);
    check("e15y_475", 160'(PlatY[159:150]), 160'd475);
    frame(10'd100, 1'b1, 1'b0, 1'b0);
    check("scroll16", 160'(Scroll), 160'd16);
    frame(10'd100, 1'b1, 1'b1, 1'b0);
    frame(10'd300, 1'b1, 1'b0, 1'b0);
    frame(10'd150, 1'b0, 1'b0, 1'b0);
    frame(10'd200, 1'b1, 1'b0, 1'b0);
    frame(10'd199, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 14; n++) begin
      frame(10'($urandom_range(230, 100)), 1'($urandom_range(3, 0) != 0), 1'b0, 1'b1);
    end

    // Reset while entry 7 is about to be scanned.
    BallY = 10'd150;
    run   = 1'b1;
    @(posedge Clk);
    #1;
    frame_clk = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    init_model();
    check("mid_rst_busy", 160'(busy), 160'd0);
    check("mid_rst_score", 160'(Score), 160'd0);
    check("mid_rst_over", 160'(overrun), 160'd0);
    check_table("mid_rst_table");
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    frame(10'd180, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/platform_scheduler.md
Name: platform_scheduler

Overview:
Owns the 16-entry platform position table that the pixel color mapper draws from. It replaces the fixed platform constants with per-frame state. On each frame start it computes a scroll amount from the player's height. It then walks the table one entry per clock, shifting every platform down, and respawns platforms that fall off the bottom at the top with a pseudo-random X. Results are published atomically, so the color mapper never sees a half-updated frame.

Parameters:
NUM_PLAT, 16, number of platform entries (power of two; index width = log2)
SCREEN_H, 480, visible lines; Y wraps modulo this
SCROLL_LINE, 200, ball Y above which (smaller Y) the world scrolls
MAX_SCROLL, 16, clamp on per-frame scroll in lines
X_MARGIN, 64, left offset added to the random respawn X
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  VGA vsync-derived frame signal, level, asynchronous to Clk
run  in  1  game-running qualifier; 0 freezes table
BallY  in  10  player centre Y, sampled at frame tick
PlatX  out  NUM_PLAT*10  published X centres, entry i at [10i+9:10i]
PlatY  out  NUM_PLAT*10  published Y centres, same packing
Scroll  out  10  dy applied in last completed update
update_done  out  1  one-cycle pulse when PlatX/PlatY change
busy  out  1  high in SCAN and PUBLISH
Score  out  16  cumulative scrolled lines, saturating at 16'hFFFF
overrun  out  1  sticky: frame tick arrived while busy

Behaviour:
- frame_clk passes through a 2-flop synchronizer, then rising-edge detect. A tick is a 1-cycle pulse 3 Clk cycles after the raw edge.
- Reset (async, Reset_n=0) values:
  - entry i: working and published X = 40*i+20, Y = 30*i+15.
  - Scroll=0, Score=0, update_done=0, busy=0, overrun=0, LFSR=LFSR_SEED, FSM=IDLE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every Clk cycle regardless of state.
- FSM states:
  - IDLE:
    - On tick with run=1: latch dy = min(SCROLL_LINE - BallY, MAX_SCROLL) if BallY < SCROLL_LINE, else 0.
    - dy=0: stay IDLE. No pulse; Scroll, Score and the published table are unchanged.
    - dy>0: idx=0, go to SCAN.
    - Tick with run=0: ignored.
  - SCAN: exactly NUM_PLAT cycles, entry idx per cycle.
    - sum = Y[idx] + dy, computed at 11 bits.
    - sum >= SCREEN_H: Y = sum - SCREEN_H; X = X_MARGIN + LFSR[8:0], giving range 64..575.
    - Otherwise Y = sum; X unchanged.
    - idx == NUM_PLAT-1: go to PUBLISH.
  - PUBLISH: one cycle. Copy the working table to the PlatX/PlatY registers, Scroll=dy, Score += dy (saturating). update_done=1 on the following cycle edge (registered), then go to IDLE.
- Latency: tick to update_done = NUM_PLAT+1 cycles, i.e. 17 at default.
- Tick during SCAN/PUBLISH: dropped, overrun set to 1. overrun clears only on reset.
- run falling mid-SCAN: the scan completes and publishes; run is checked only in IDLE.
- BallY outside 0..479: treated as unsigned. BallY >= SCROLL_LINE gives dy=0.
- Published outputs are stable except on the PUBLISH edge. The color mapper reads them combinationally.

Decomposition:
- Package platform_pkg: NUM_PLAT, SCREEN_H, coordinate type (10-bit), plat_t struct {x,y}, reset-layout function init_x(i)/init_y(i).
- One sub-module, lfsr16: Clk, Reset_n, seed parameter, 16-bit state out. Reused later for enemy spawn.
- The synchronizer/edge detect stays inline.

Test Plan:
- Reset release, no ticks → entry 3 reads X=140, Y=105; entry 15 reads X=620, Y=465; busy=0; update_done never pulses.
- BallY=190, run=1, frame_clk rise → update_done exactly 20 cycles after the raw edge; Scroll=10; Score=10; entry 0 Y=25; entry 15 Y=475; X unchanged.
- BallY=100 (clamped dy=16) → Scroll=16. Entry 15 (Y 465→481) wraps to Y=1 with X in 64..575 equal to 64+LFSR[8:0] at its SCAN cycle (checked against a reference model). Entry 14 Y=451.
- Second tick injected 5 cycles into SCAN → only one update_done; overrun=1 and stays 1; table reflects a single scroll.
- BallY=300 tick, and separately run=0 tick → no update_done, published table bit-identical, Score unchanged.
- Reset_n asserted mid-SCAN (idx=7) → immediate return to the reset layout, busy=0, Score=0. The next valid tick completes normally.
